// File: rtl/m68k_bus_arbiter.sv
// 68000 bus-mastership arbiter between the local bus sequencer and external DMA masters.
// Define ARB_WATCHDOG_EN to add the sticky external-hold watchdog (hold_timeout_o).
`timescale 1ns/1ps

module m68k_bus_arbiter #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_HOLD    = 1024
) (
    input  logic       pi_clk_i,
    input  logic       rst_i,
    input  logic       m68k_clk_i,
    input  logic       m68k_br_n_i,
    input  logic       m68k_bgack_n_i,
    input  logic       loc_req_i,
    input  logic       loc_busy_i,
    output logic       loc_gnt_o,
    output logic       bus_oe_o,
    output logic       m68k_bg_n_o,
    output logic       ext_owner_o,
    output logic [2:0] arb_state_o,
    output logic       hold_timeout_o
);

    // Fewer than two flops is not a safe synchronizer, so the depth is clamped.
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        ARB_OWN     = 3'd0,
        ARB_DRAIN   = 3'd1,
        ARB_GRANT   = 3'd2,
        ARB_EXT     = 3'd3,
        ARB_RECLAIM = 3'd4
    } arb_state_t;

    arb_state_t        state_q, state_d;

    logic [2:0]        clkSync_q;
    logic [SYNC_N-1:0] brSync_q;
    logic [SYNC_N-1:0] bgackSync_q;

    logic              tick;
    logic              br;
    logic              bgack;

    logic              locGnt_q,   locGnt_d;
    logic              busOe_q,    busOe_d;
    logic              bgN_q,      bgN_d;
    logic              extOwner_q, extOwner_d;
    logic [2:0]        arbState_q;

    always_ff @(posedge pi_clk_i or posedge rst_i) begin
        if (rst_i) begin
            clkSync_q   <= 3'b000;
            brSync_q    <= '1;
            bgackSync_q <= '1;
        end else begin
            clkSync_q   <= {clkSync_q[1:0], m68k_clk_i};
            brSync_q    <= {brSync_q[SYNC_N-2:0], m68k_br_n_i};
            bgackSync_q <= {bgackSync_q[SYNC_N-2:0], m68k_bgack_n_i};
        end
    end

    // Bit 2 is the older sample, so 1->0 across [2:1] marks a falling M68K_CLK edge.
    assign tick  = clkSync_q[2] & ~clkSync_q[1];
    assign br    = ~brSync_q[SYNC_N-1];
    assign bgack = ~bgackSync_q[SYNC_N-1];

    always_ff @(posedge pi_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ARB_OWN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_OWN: begin
                if (tick && br) begin
                    state_d = loc_busy_i ? ARB_DRAIN : ARB_GRANT;
                end
            end
            ARB_DRAIN: begin
                if (tick) begin
                    if (!br) begin
                        state_d = ARB_OWN;
                    end else if (!loc_busy_i) begin
                        state_d = ARB_GRANT;
                    end
                end
            end
            ARB_GRANT: begin
                if (tick) begin
                    if (bgack) begin
                        state_d = ARB_EXT;
                    end else if (!br) begin
                        state_d = ARB_RECLAIM;
                    end
                end
            end
            ARB_EXT: begin
                if (tick && !bgack) begin
                    state_d = br ? ARB_GRANT : ARB_RECLAIM;
                end
            end
            ARB_RECLAIM: begin
                if (tick) begin
                    state_d = ARB_OWN;
                end
            end
            default: begin
                state_d = ARB_OWN;
            end
        endcase
    end

    // Outputs decode the current state and are registered, so pins follow the state by one clock.
    always_comb begin
        locGnt_d   = 1'b0;
        busOe_d    = 1'b0;
        bgN_d      = 1'b1;
        extOwner_d = 1'b0;
        case (state_q)
            ARB_OWN: begin
                busOe_d  = 1'b1;
                locGnt_d = loc_req_i & ~br;
            end
            ARB_DRAIN: begin
                busOe_d = 1'b1;
            end
            ARB_GRANT: begin
                bgN_d = 1'b0;
            end
            ARB_EXT: begin
                extOwner_d = 1'b1;
                bgN_d      = ~br;
            end
            default: begin
                busOe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pi_clk_i or posedge rst_i) begin
        if (rst_i) begin
            locGnt_q   <= 1'b0;
            busOe_q    <= 1'b1;
            bgN_q      <= 1'b1;
            extOwner_q <= 1'b0;
            arbState_q <= ARB_OWN;
        end else begin
            locGnt_q   <= locGnt_d;
            busOe_q    <= busOe_d;
            bgN_q      <= bgN_d;
            extOwner_q <= extOwner_d;
            arbState_q <= state_q;
        end
    end

    assign loc_gnt_o   = locGnt_q;
    assign bus_oe_o    = busOe_q;
    assign m68k_bg_n_o = bgN_q;
    assign ext_owner_o = extOwner_q;
    assign arb_state_o = arbState_q;

`ifdef ARB_WATCHDOG_EN
    localparam logic [15:0] MAX_HOLD_W = 16'(MAX_HOLD);

    logic [15:0] holdCnt_q,     holdCnt_d;
    logic        holdTimeout_q, holdTimeout_d;

    // The count saturates rather than wrapping so a very long hold cannot look short.
    always_comb begin
        holdCnt_d     = holdCnt_q;
        holdTimeout_d = holdTimeout_q;
        if (state_q != ARB_EXT) begin
            holdCnt_d = 16'd0;
        end else if (tick && (holdCnt_q != 16'hFFFF)) begin
            holdCnt_d = holdCnt_q + 16'd1;
            if (holdCnt_d >= MAX_HOLD_W) begin
                holdTimeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge pi_clk_i or posedge rst_i) begin
        if (rst_i) begin
            holdCnt_q     <= 16'd0;
            holdTimeout_q <= 1'b0;
        end else begin
            holdCnt_q     <= holdCnt_d;
            holdTimeout_q <= holdTimeout_d;
        end
    end

    assign hold_timeout_o = holdTimeout_q;
`else
    localparam logic [15:0] MAX_HOLD_W = 16'(MAX_HOLD);

    logic unused_maxHold;
    assign unused_maxHold = ^MAX_HOLD_W;

    assign hold_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// Directed, table-driven bench for m68k_bus_arbiter; watchdog steps run when ARB_WATCHDOG_EN is defined.
`timescale 1ns/1ps

module tb_m68k_bus_arbiter;

    // {brN, bgackN, locReq, locBusy} in, {state[2:0], bgN, busOe, locGnt, extOwner} expected.
    typedef struct {
        string      name;
        logic [3:0] in;
        logic [6:0] exp;
    } vec_t;

    logic       piClk = 1'b0;
    logic       rst = 1'b1;
    logic       m68kClk = 1'b0;
    logic       brN = 1'b1;
    logic       bgackN = 1'b1;
    logic       locReq = 1'b0;
    logic       locBusy = 1'b0;
    logic       locGnt;
    logic       busOe;
    logic       bgN;
    logic       extOwner;
    logic [2:0] arbState;
    logic       holdTimeout;

    int checks = 0;
    int errors = 0;

    vec_t vecs[24];

    always #2.5 piClk = ~piClk;
    always #70  m68kClk = ~m68kClk;

    m68k_bus_arbiter #(
        .SYNC_STAGES(2),
        .MAX_HOLD   (8)
    ) dut (
        .pi_clk_i      (piClk),
        .rst_i         (rst),
        .m68k_clk_i    (m68kClk),
        .m68k_br_n_i   (brN),
        .m68k_bgack_n_i(bgackN),
        .loc_req_i     (locReq),
        .loc_busy_i    (locBusy),
        .loc_gnt_o     (locGnt),
        .bus_oe_o      (busOe),
        .m68k_bg_n_o   (bgN),
        .ext_owner_o   (extOwner),
        .arb_state_o   (arbState),
        .hold_timeout_o(holdTimeout)
    );

    function automatic vec_t mkVec(input string n, input logic [3:0] i, input logic [6:0] e);
        vec_t v;
        v.name = n;
        v.in   = i;
        v.exp  = e;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // One step = inputs change mid-high-phase, exactly one falling M68K_CLK edge is seen, outputs settle.
    task automatic applyStimulus(input vec_t v);
        @(posedge m68kClk);
        #1;
        brN     = v.in[3];
        bgackN  = v.in[2];
        locReq  = v.in[1];
        locBusy = v.in[0];
        @(negedge m68kClk);
        repeat (6) @(negedge piClk);
    endtask

    task automatic checkState(input string name, input logic [6:0] e);
        checkOutput({name, ".state"},     int'(arbState), int'(e[6:4]));
        checkOutput({name, ".bg_n"},      int'(bgN),      int'(e[3]));
        checkOutput({name, ".bus_oe"},    int'(busOe),    int'(e[2]));
        checkOutput({name, ".loc_gnt"},   int'(locGnt),   int'(e[1]));
        checkOutput({name, ".ext_owner"}, int'(extOwner), int'(e[0]));
    endtask

    task automatic runVec(input vec_t v);
        applyStimulus(v);
        checkState(v.name, v.exp);
    endtask

    task automatic monitorInvariants();
        forever begin
            @(negedge piClk);
            if (!rst) begin
                checks++;
                assert (!(busOe && (!bgN || extOwner))) else begin
                    errors++;
                    $display("[TB] FAIL bus_oe_invariant bus_oe=%0d bg_n=%0d ext_owner=%0d required bus_oe=0",
                             busOe, bgN, extOwner);
                end
                checks++;
                assert (!(locGnt && (arbState != 3'd0))) else begin
                    errors++;
                    $display("[TB] FAIL loc_gnt_invariant loc_gnt=%0d arb_state=%0d required loc_gnt=0",
                             locGnt, arbState);
                end
            end
        end
    endtask

    initial begin
        int n;

        vecs[0]  = mkVec("own_idle",       4'b1110, 7'b000_1110);
        vecs[1]  = mkVec("req_vs_br",      4'b0110, 7'b010_0000);
        vecs[2]  = mkVec("grant_hold",     4'b0110, 7'b010_0000);
        vecs[3]  = mkVec("ext_enter",      4'b1000, 7'b011_1001);
        vecs[4]  = mkVec("ext_hold",       4'b1000, 7'b011_1001);
        vecs[5]  = mkVec("ext_release",    4'b1100, 7'b100_1000);
        vecs[6]  = mkVec("reclaim_own",    4'b1110, 7'b000_1110);
        vecs[7]  = mkVec("drain_enter",    4'b0101, 7'b001_1100);
        vecs[8]  = mkVec("drain_wait1",    4'b0101, 7'b001_1100);
        vecs[9]  = mkVec("drain_wait2",    4'b0101, 7'b001_1100);
        vecs[10] = mkVec("drain_wait3",    4'b0101, 7'b001_1100);
        vecs[11] = mkVec("drain_wait4",    4'b0101, 7'b001_1100);
        vecs[12] = mkVec("drain_done",     4'b0100, 7'b010_0000);
        vecs[13] = mkVec("withdraw",       4'b1100, 7'b100_1000);
        vecs[14] = mkVec("withdraw_own",   4'b1110, 7'b000_1110);
        vecs[15] = mkVec("chain_grant",    4'b0110, 7'b010_0000);
        vecs[16] = mkVec("chain_ext1",     4'b0000, 7'b011_0001);
        vecs[17] = mkVec("chain_regrant",  4'b0100, 7'b010_0000);
        vecs[18] = mkVec("chain_ext2",     4'b1000, 7'b011_1001);
        vecs[19] = mkVec("chain_release",  4'b1100, 7'b100_1000);
        vecs[20] = mkVec("chain_own",      4'b1100, 7'b000_1100);
        vecs[21] = mkVec("drain_again",    4'b0111, 7'b001_1100);
        vecs[22] = mkVec("drain_withdraw", 4'b1111, 7'b000_1110);
        vecs[23] = mkVec("own_no_req",     4'b1101, 7'b000_1100);

        fork
            monitorInvariants();
        join_none

        // Reset values while held, with a live request pending on the pins.
        brN    = 1'b0;
        locReq = 1'b1;
        repeat (10) @(negedge piClk);
        checkState("reset", 7'b000_1100);
        checkOutput("reset.hold_timeout", int'(holdTimeout), 0);

        brN = 1'b1;
        rst = 1'b0;
        @(negedge piClk);
        checkState("post_reset", 7'b000_1110);

        for (int i = 0; i < 24; i++) begin
            runVec(vecs[i]);
            checkOutput({vecs[i].name, ".hold_timeout"}, int'(holdTimeout), 0);
        end

        // Grant latency from a BR_n fall just after a tick.
        locBusy = 1'b0;
        @(negedge m68kClk);
        repeat (5) @(negedge piClk);
        brN = 1'b0;
        n = 0;
        while ((bgN !== 1'b0) && (n < 60)) begin
            @(negedge piClk);
            n++;
        end
        checkOutput("bg_latency_within_bound", int'(n <= 34), 1);
        checkOutput("bg_latency.state", int'(arbState), 2);
        runVec(mkVec("lat_withdraw", 4'b1100, 7'b100_1000));
        runVec(mkVec("lat_own",      4'b1100, 7'b000_1100));

`ifdef ARB_WATCHDOG_EN
        runVec(mkVec("wd_grant", 4'b0100, 7'b010_0000));
        runVec(mkVec("wd_ext",   4'b1000, 7'b011_1001));
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(mkVec("wd_hold", 4'b1000, 7'b011_1001));
            checkOutput($sformatf("wd_tick%0d.hold_timeout", k), int'(holdTimeout), (k >= 8) ? 1 : 0);
            checkOutput($sformatf("wd_tick%0d.state", k), int'(arbState), 3);
        end
        runVec(mkVec("wd_release", 4'b1100, 7'b100_1000));
        runVec(mkVec("wd_own",     4'b1100, 7'b000_1100));
        checkOutput("wd_sticky.hold_timeout", int'(holdTimeout), 1);
`else
        checkOutput("wd_tied0.hold_timeout", int'(holdTimeout), 0);
`endif

        // Reset asserted while an external master owns the bus takes effect without a clock.
        runVec(mkVec("mid_grant", 4'b0100, 7'b010_0000));
        runVec(mkVec("mid_ext",   4'b1000, 7'b011_1001));
        @(negedge piClk);
        #1;
        rst = 1'b1;
        #1;
        checkState("mid_reset", 7'b000_1100);
        checkOutput("mid_reset.hold_timeout", int'(holdTimeout), 0);
        repeat (3) @(negedge piClk);
        brN    = 1'b1;
        bgackN = 1'b1;
        locReq = 1'b1;
        rst    = 1'b0;
        @(negedge piClk);
        checkState("mid_reset_own", 7'b000_1110);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
